// File: rtl/overlay_sequencer.sv
// rtl/overlay_sequencer.sv - frame-synchronous display mode and judgment overlay sequencer
//
// Drives the select and overlay controls of the pixel output mux. Display mode
// advances on a button pulse; a judgment result is shown solid, then blinks,
// then turns off. Every output change lands on a frame boundary so no frame is
// torn.
//
// Ports:
//   clk_in               pixel clock
//   rst_n_in             asynchronous active-low reset (released synchronously)
//   new_frame_in         one-cycle pulse at the start of each frame
//   mode_btn_in          one-cycle debounced pulse, advance display mode
//   judgment_valid_in    one-cycle pulse, a judgment result is ready
//   judgment_correct_in  judgment result, sampled with judgment_valid_in
//   bg_out               background select (1 = threshold view)
//   target_out           overlay enable (mode bit OR active judgment)
//   judgment_out         frame-level judgment enable
//   judgment_correct_out latched result of the active judgment
//   mode_out             applied display mode
module overlay_sequencer #(
  parameter int SHOW_FRAMES   = 60,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       new_frame_in,
  input  logic       mode_btn_in,
  input  logic       judgment_valid_in,
  input  logic       judgment_correct_in,
  output logic       bg_out,
  output logic       target_out,
  output logic       judgment_out,
  output logic       judgment_correct_out,
  output logic [1:0] mode_out
);

  // frame_cnt must reach SHOW_FRAMES-1 and BLINK_FRAMES-1; tog_cnt never has
  // to hold BLINK_TOGGLES itself because the last toggle exits to IDLE.
  localparam int FC_MAX   = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
  localparam int FC_W     = (FC_MAX > 2) ? $clog2(FC_MAX) : 1;
  localparam int TOG_W    = (BLINK_TOGGLES > 2) ? $clog2(BLINK_TOGGLES) : 1;
  localparam int TOG_LAST_I = (BLINK_TOGGLES > 0) ? BLINK_TOGGLES - 1 : 0;

  localparam logic [FC_W-1:0]  SHOW_LAST  = FC_W'(SHOW_FRAMES - 1);
  localparam logic [FC_W-1:0]  BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
  localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(TOG_LAST_I);
  localparam logic [TOG_W-1:0] TOG_ONE    = TOG_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLINK = 2'd2;

  // Reset asserts immediately but releases two clocks later, aligned to clk_in.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic [1:0]       pend_mode;
  logic             pend_flag;
  logic             pend_result;
  logic [1:0]       state;
  logic [FC_W-1:0]  frame_cnt;
  logic [TOG_W-1:0] tog_cnt;

  logic [1:0]       pend_mode_nxt;
  logic             pflag_eff;
  logic             pres_eff;
  logic [1:0]       state_nxt;
  logic [FC_W-1:0]  fc_nxt;
  logic [TOG_W-1:0] tog_nxt;
  logic             corr_nxt;
  logic             judg_nxt;

  // Effective pending values fold in a request arriving in the boundary cycle
  // itself, so that request is consumed at that same boundary.
  always_comb begin
    pend_mode_nxt = mode_btn_in ? (pend_mode + 2'd1) : pend_mode;
    pflag_eff     = pend_flag | judgment_valid_in;
    pres_eff      = judgment_valid_in ? judgment_correct_in : pend_result;

    state_nxt = state;
    fc_nxt    = frame_cnt;
    tog_nxt   = tog_cnt;
    corr_nxt  = judgment_correct_out;

    case (state)
      ST_IDLE: begin
        if (pflag_eff) begin
          state_nxt = ST_SHOW;
          fc_nxt    = '0;
          tog_nxt   = '0;
          corr_nxt  = pres_eff;
        end
      end
      ST_SHOW: begin
        if (pflag_eff) begin
          fc_nxt   = '0;
          tog_nxt  = '0;
          corr_nxt = pres_eff;
        end else if (frame_cnt == SHOW_LAST) begin
          state_nxt = (BLINK_TOGGLES == 0) ? ST_IDLE : ST_BLINK;
          fc_nxt    = '0;
          tog_nxt   = '0;
        end else begin
          fc_nxt = frame_cnt + FC_ONE;
        end
      end
      ST_BLINK: begin
        if (pflag_eff) begin
          state_nxt = ST_SHOW;
          fc_nxt    = '0;
          tog_nxt   = '0;
          corr_nxt  = pres_eff;
        end else if (frame_cnt == BLINK_LAST) begin
          fc_nxt = '0;
          if (tog_cnt == TOG_LAST) begin
            state_nxt = ST_IDLE;
            tog_nxt   = '0;
          end else begin
            tog_nxt = tog_cnt + TOG_ONE;
          end
        end else begin
          fc_nxt = frame_cnt + FC_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        fc_nxt    = '0;
        tog_nxt   = '0;
      end
    endcase

    // Blink starts dark: even half-periods off, odd half-periods on.
    judg_nxt = (state_nxt == ST_SHOW) | ((state_nxt == ST_BLINK) & tog_nxt[0]);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_mode            <= 2'd0;
      pend_flag            <= 1'b0;
      pend_result          <= 1'b0;
      state                <= ST_IDLE;
      frame_cnt            <= '0;
      tog_cnt              <= '0;
      mode_out             <= 2'd0;
      bg_out               <= 1'b0;
      target_out           <= 1'b0;
      judgment_out         <= 1'b0;
      judgment_correct_out <= 1'b0;
    end else begin
      pend_mode   <= pend_mode_nxt;
      pend_result <= pres_eff;
      if (new_frame_in) begin
        pend_flag            <= 1'b0;
        state                <= state_nxt;
        frame_cnt            <= fc_nxt;
        tog_cnt              <= tog_nxt;
        mode_out             <= pend_mode_nxt;
        bg_out               <= pend_mode_nxt[1];
        target_out           <= pend_mode_nxt[0] | judg_nxt;
        judgment_out         <= judg_nxt;
        judgment_correct_out <= corr_nxt;
      end else begin
        pend_flag <= pflag_eff;
      end
    end
  end

endmodule

// File: tb/tb_overlay_sequencer.sv
// tb/tb_overlay_sequencer.sv - self-checking bench for overlay_sequencer
module tb_overlay_sequencer;

  localparam int SF = 3;
  localparam int BF = 2;
  localparam int TG = 4;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic new_frame_in = 1'b0;
  logic mode_btn_in = 1'b0;
  logic judgment_valid_in = 1'b0;
  logic judgment_correct_in = 1'b0;

  logic       a_bg, a_tgt, a_judg, a_corr;
  logic [1:0] a_mode;
  logic       b_bg, b_tgt, b_judg, b_corr;
  logic [1:0] b_mode;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode as a pending counter, judgment as "frames since start"
  logic [1:0] m_mode, m_pmode;
  bit         m_pflag, m_pres, m_active, m_corr;
  int         m_k;

  overlay_sequencer #(.SHOW_FRAMES(SF), .BLINK_FRAMES(BF), .BLINK_TOGGLES(TG)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
    .mode_btn_in(mode_btn_in), .judgment_valid_in(judgment_valid_in),
    .judgment_correct_in(judgment_correct_in), .bg_out(a_bg), .target_out(a_tgt),
    .judgment_out(a_judg), .judgment_correct_out(a_corr), .mode_out(a_mode)
  );

  overlay_sequencer #(.SHOW_FRAMES(SF), .BLINK_FRAMES(BF), .BLINK_TOGGLES(0)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
    .mode_btn_in(mode_btn_in), .judgment_valid_in(judgment_valid_in),
    .judgment_correct_in(judgment_correct_in), .bg_out(b_bg), .target_out(b_tgt),
    .judgment_out(b_judg), .judgment_correct_out(b_corr), .mode_out(b_mode)
  );

  always #5 clk_in = ~clk_in;

  // Visibility of a judgment k frames after it started: solid for SF frames,
  // then tog half-periods of BF frames (odd ones lit), then dark forever.
  function automatic bit vis(input int k, input int tog);
    int h;
    if (k < SF) return 1'b1;
    h = (k - SF) / BF;
    if (h < tog) return (h % 2) == 1;
    return 1'b0;
  endfunction

  function automatic bit exp_ja();
    return m_active && vis(m_k, TG);
  endfunction

  function automatic bit exp_jb();
    return m_active && vis(m_k, 0);
  endfunction

  task automatic model_clear();
    m_mode = 2'd0; m_pmode = 2'd0; m_pflag = 0; m_pres = 0;
    m_active = 0; m_corr = 0; m_k = 0;
  endtask

  task automatic cyc(input bit nf, input bit btn, input bit v, input bit c);
    new_frame_in = nf; mode_btn_in = btn; judgment_valid_in = v; judgment_correct_in = c;
    @(posedge clk_in);
    if (btn) m_pmode = m_pmode + 2'd1;
    if (v) begin m_pflag = 1; m_pres = c; end
    if (nf) begin
      m_mode = m_pmode;
      if (m_pflag) begin
        m_active = 1; m_k = 0; m_corr = m_pres; m_pflag = 0;
      end else if (m_active && m_k < 1000) begin
        m_k++;
      end
    end
    #1;
    new_frame_in = 0; mode_btn_in = 0; judgment_valid_in = 0; judgment_correct_in = 0;
  endtask

  task automatic boundary();
    cyc(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    model_clear();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n_in = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (a_mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d want 0", a_mode); end
    n_cmp++; if (a_bg !== 1'b0) begin n_bad++; $display("FAIL reset_bg: got %b want 0", a_bg); end
    n_cmp++; if (a_tgt !== 1'b0) begin n_bad++; $display("FAIL reset_tgt: got %b want 0", a_tgt); end
    n_cmp++; if (a_judg !== 1'b0) begin n_bad++; $display("FAIL reset_judg: got %b want 0", a_judg); end
    n_cmp++; if (a_corr !== 1'b0) begin n_bad++; $display("FAIL reset_corr: got %b want 0", a_corr); end
    n_cmp++; if ({b_bg, b_tgt, b_judg, b_corr, b_mode} !== 6'd0) begin
      n_bad++; $display("FAIL reset_b: got %b want 000000", {b_bg, b_tgt, b_judg, b_corr, b_mode});
    end
  endtask

  task automatic test_mode();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++; if (a_mode !== 2'd0) begin n_bad++; $display("FAIL mode_before_boundary: got %0d want 0", a_mode); end
    boundary();
    n_cmp++; if (a_mode !== 2'd1) begin n_bad++; $display("FAIL mode_one_press: got %0d want 1", a_mode); end
    n_cmp++; if (a_bg !== 1'b0 || a_tgt !== 1'b1) begin
      n_bad++; $display("FAIL mode1_decode: got bg=%b tgt=%b want bg=0 tgt=1", a_bg, a_tgt);
    end
    repeat (4) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    boundary();
    n_cmp++; if (a_mode !== 2'd1) begin n_bad++; $display("FAIL mode_four_press: got %0d want 1", a_mode); end
    cyc(1, 1, 0, 0);
    n_cmp++; if (a_mode !== 2'd2) begin n_bad++; $display("FAIL mode_coincident: got %0d want 2", a_mode); end
    n_cmp++; if (a_bg !== 1'b1 || a_tgt !== 1'b0) begin
      n_bad++; $display("FAIL mode2_decode: got bg=%b tgt=%b want bg=1 tgt=0", a_bg, a_tgt);
    end
    cyc(0, 1, 0, 0);
    boundary();
    n_cmp++; if (a_mode !== 2'd3 || a_bg !== 1'b1 || a_tgt !== 1'b1) begin
      n_bad++; $display("FAIL mode3: got mode=%0d bg=%b tgt=%b want 3 1 1", a_mode, a_bg, a_tgt);
    end
    cyc(0, 1, 0, 0);
    boundary();
    n_cmp++; if (a_mode !== 2'd0 || a_mode !== m_mode) begin
      n_bad++; $display("FAIL mode_wrap: got %0d want 0", a_mode);
    end
  endtask

  task automatic test_judgment();
    int pat[13] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    for (int f = 0; f < 13; f++) begin
      boundary();
      n_cmp++; if (a_judg !== pat[f][0] || a_tgt !== pat[f][0]) begin
        n_bad++; $display("FAIL judg_seq[%0d]: got judg=%b tgt=%b want %0d", f, a_judg, a_tgt, pat[f]);
      end
      n_cmp++; if (a_corr !== 1'b1) begin n_bad++; $display("FAIL judg_corr[%0d]: got %b want 1", f, a_corr); end
      n_cmp++; if (b_judg !== (f < SF)) begin
        n_bad++; $display("FAIL judg_notog[%0d]: got %b want %b", f, b_judg, f < SF);
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      n_cmp++; if (a_judg !== exp_ja()) begin
        n_bad++; $display("FAIL judg_midframe[%0d]: got %b want %b", f, a_judg, exp_ja());
      end
    end
  endtask

  task automatic test_retrigger();
    cyc(0, 0, 1, 1);
    repeat (4) begin boundary(); cyc(0, 0, 0, 0); end
    n_cmp++; if (a_judg !== 1'b0) begin n_bad++; $display("FAIL retrig_in_blink: got %b want 0", a_judg); end
    cyc(0, 0, 1, 0);
    boundary();
    n_cmp++; if (a_judg !== 1'b1 || a_corr !== 1'b0) begin
      n_bad++; $display("FAIL retrig_restart: got judg=%b corr=%b want 1 0", a_judg, a_corr);
    end
    for (int f = 1; f < 4; f++) begin
      cyc(0, 0, 0, 0);
      boundary();
      n_cmp++; if (a_judg !== (f < SF)) begin
        n_bad++; $display("FAIL retrig_solid[%0d]: got %b want %b", f, a_judg, f < SF);
      end
    end
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    boundary();
    n_cmp++; if (a_corr !== 1'b0 || a_judg !== 1'b1) begin
      n_bad++; $display("FAIL last_wins_0: got corr=%b judg=%b want 0 1", a_corr, a_judg);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    boundary();
    n_cmp++; if (a_corr !== 1'b1) begin n_bad++; $display("FAIL last_wins_1: got %b want 1", a_corr); end
    repeat (15) boundary();
    n_cmp++; if (a_judg !== 1'b0 || a_corr !== 1'b1) begin
      n_bad++; $display("FAIL idle_hold: got judg=%b corr=%b want 0 1", a_judg, a_corr);
    end
  endtask

  task automatic test_collision();
    cyc(1, 0, 1, 0);
    n_cmp++; if (a_judg !== 1'b1 || b_judg !== 1'b1 || a_corr !== 1'b0) begin
      n_bad++; $display("FAIL collide: got a=%b b=%b corr=%b want 1 1 0", a_judg, b_judg, a_corr);
    end
    for (int f = 1; f < 8; f++) begin
      boundary();
      n_cmp++; if (b_judg !== (f < SF) || b_tgt !== (f < SF)) begin
        n_bad++; $display("FAIL notog_idle[%0d]: got %b want %b", f, b_judg, f < SF);
      end
      n_cmp++; if (a_judg !== exp_ja()) begin
        n_bad++; $display("FAIL collide_a[%0d]: got %b want %b", f, a_judg, exp_ja());
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    boundary();
    boundary();
    cyc(0, 0, 1, 1);
    #3 rst_n_in = 1'b0;
    #1;
    n_cmp++; if ({a_bg, a_tgt, a_judg, a_corr, a_mode} !== 6'd0) begin
      n_bad++; $display("FAIL async_reset_a: got %b want 000000", {a_bg, a_tgt, a_judg, a_corr, a_mode});
    end
    n_cmp++; if ({b_bg, b_tgt, b_judg, b_corr, b_mode} !== 6'd0) begin
      n_bad++; $display("FAIL async_reset_b: got %b want 000000", {b_bg, b_tgt, b_judg, b_corr, b_mode});
    end
    do_reset();
    for (int f = 0; f < 4; f++) begin
      boundary();
      n_cmp++; if (a_judg !== 1'b0 || a_mode !== 2'd0 || b_judg !== 1'b0) begin
        n_bad++; $display("FAIL post_reset[%0d]: got judg=%b mode=%0d bj=%b want 0 0 0", f, a_judg, a_mode, b_judg);
      end
    end
  endtask

  task automatic test_random();
    int len;
    bit btn, v, c;
    for (int fr = 0; fr < 80; fr++) begin
      len = $urandom_range(2, 5);
      for (int i = 0; i < len; i++) begin
        btn = ($urandom_range(0, 5) == 0);
        v   = ($urandom_range(0, 24) == 0);
        c   = $urandom_range(0, 1) == 1;
        cyc(i == 0, btn, v, c);
        n_cmp++; if (a_mode !== m_mode || a_bg !== m_mode[1] || a_tgt !== (m_mode[0] | exp_ja())) begin
          n_bad++; $display("FAIL rand_mode_a: got mode=%0d bg=%b tgt=%b want %0d %b %b",
                            a_mode, a_bg, a_tgt, m_mode, m_mode[1], m_mode[0] | exp_ja());
        end
        n_cmp++; if (a_judg !== exp_ja() || a_corr !== m_corr) begin
          n_bad++; $display("FAIL rand_judg_a: got %b/%b want %b/%b", a_judg, a_corr, exp_ja(), m_corr);
        end
        n_cmp++; if (b_mode !== m_mode || b_judg !== exp_jb() || b_corr !== m_corr ||
                     b_tgt !== (m_mode[0] | exp_jb()) || b_bg !== m_mode[1]) begin
          n_bad++; $display("FAIL rand_b: got mode=%0d judg=%b corr=%b tgt=%b want %0d %b %b %b",
                            b_mode, b_judg, b_corr, b_tgt, m_mode, exp_jb(), m_corr, m_mode[0] | exp_jb());
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_mode();
    test_judgment();
    test_retrigger();
    test_collision();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
